// File: rtl/rom_pkg.sv
// Shared types and constants for the ROM responder and its line buffer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rom_pkg;

    localparam int ROM_AW = 22;
    localparam int MEM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Little-endian byte pick out of a 16-bit SRAM word.
    function automatic logic [7:0] byte_sel(input logic [MEM_DW-1:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/rom_resp_cache.sv
// One-word line buffer: remembers the last SRAM word read, tag = word address.
// Latency: hit/hit_data are combinational on lookup_tag; fill is written on the clock edge.
// Backpressure: none; fill is a one-cycle strobe from the responder.
module rom_resp_cache
    import rom_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ROM_AW-2:0]     lookup_tag,
    input  logic                  fill,
    input  logic [ROM_AW-2:0]     fill_tag,
    input  logic [MEM_DW-1:0]     fill_data,
    output logic                  hit,
    output logic [MEM_DW-1:0]     hit_data
);

    logic                  valid;
    logic [ROM_AW-2:0]     tag;
    logic [MEM_DW-1:0]     data;

    // Capture every completed SRAM word; reset only needs to drop valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end
    end

    assign hit      = valid && (tag == lookup_tag);
    assign hit_data = data;

endmodule

// File: rtl/rom_resp.sv
// ROM byte responder: 4-phase romreq/romack front end over a 16-bit async SRAM (ROM_RESP_CACHE_EN adds a line buffer).
// Latency: romack rises WAIT+2 edges after romreq is sampled (1 edge on a line-buffer hit).
// Backpressure: requester holds romreq until romack; romack holds until romreq is seen low.
module rom_resp
    import rom_pkg::*;
#(
    parameter int WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ROM_AW-1:0]     romaddr,
    input  logic                  romreq,
    output logic                  romack,
    output logic [7:0]            romdata,
    output logic [ROM_AW-2:0]     memaddr,
    input  logic [MEM_DW-1:0]     memdata,
    output logic                  memce_n,
    output logic                  memoe_n
);

    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [ROM_AW-1:0]   addr, addr_n;
    logic                romack_n;
    logic [7:0]          romdata_n;
    logic                hit;
    logic [MEM_DW-1:0]   hit_data;

    // SRAM word address always follows the latched request address.
    assign memaddr = addr[ROM_AW-1:1];

`ifdef ROM_RESP_CACHE_EN
    logic fill;
    assign fill = (state == READ) && (cnt == '0);

    rom_resp_cache u_cache (
        .clk        (clk),
        .rstn       (rstn),
        .lookup_tag (romaddr[ROM_AW-1:1]),
        .fill       (fill),
        .fill_tag   (addr[ROM_AW-1:1]),
        .fill_data  (memdata),
        .hit        (hit),
        .hit_data   (hit_data)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // Next-state and datapath decode; romack goes high on the cycle after ACK
    // is entered, so an early-dropped romreq still sees a one-cycle pulse.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_n    = addr;
        romack_n  = romack;
        romdata_n = romdata;
        case (state)
            IDLE: begin
                romack_n = 1'b0;
                if (romreq) begin
                    addr_n = romaddr;
                    if (hit) begin
                        state_n   = ACK;
                        romdata_n = byte_sel(hit_data, romaddr[0]);
                    end else begin
                        state_n = READ;
                        cnt_n   = CW'(WAIT);
                    end
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_n   = ACK;
                    romdata_n = byte_sel(memdata, addr[0]);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ACK: begin
                romack_n = 1'b1;
                if (romack && !romreq) begin
                    state_n  = IDLE;
                    romack_n = 1'b0;
                end
            end
            default: begin
                state_n  = IDLE;
                romack_n = 1'b0;
            end
        endcase
    end

    // State and registered outputs; SRAM strobes are low exactly while in READ.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            romack  <= 1'b0;
            romdata <= '0;
            memce_n <= 1'b1;
            memoe_n <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr    <= addr_n;
            romack  <= romack_n;
            romdata <= romdata_n;
            memce_n <= (state_n != READ);
            memoe_n <= (state_n != READ);
        end
    end

endmodule

// File: tb/tb_rom_resp.sv
// Bench for rom_resp: directed table, randomized requests against a line-buffer aware model,
// early-drop, mid-read reset and WAIT=0 back-to-back sequences.
// Handshake is driven 4-phase; outputs are sampled 1 time unit after the rising edge.
module tb_rom_resp;

    localparam int WAIT = 3;
`ifdef ROM_RESP_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [21:0] romaddr;
    logic        romreq;
    logic        romack;
    logic [7:0]  romdata;
    logic [20:0] memaddr;
    logic [15:0] memdata;
    logic        memce_n;
    logic        memoe_n;

    logic [21:0] a0;
    logic        req0;
    logic        ack0;
    logic [7:0]  data0;
    logic [20:0] maddr0;
    logic [15:0] mdata0;
    logic        ce0;
    logic        oe0;

    int checks = 0;
    int errors = 0;

    // Reference line-buffer state: last word fetched from SRAM.
    bit          mv = 1'b0;
    logic [20:0] mt = '0;

    always #5 clk = ~clk;

    // SRAM contents: low words read as 0xBEEF, the rest a scrambled pattern.
    function automatic logic [15:0] memword(input logic [20:0] w);
        logic [15:0] h;
        if (w < 21'd32) return 16'hBEEF;
        h = w[15:0] * 16'd40503;
        return h ^ {11'd0, w[20:16]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [21:0] a);
        logic [15:0] w;
        w = memword(a[21:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic int exp_lat(input logic [21:0] a);
        return (CACHE && mv && (mt == a[21:1])) ? 1 : WAIT + 2;
    endfunction

    assign memdata = memword(memaddr);
    assign mdata0  = memword(maddr0);

    rom_resp #(.WAIT(WAIT)) dut (
        .clk(clk), .rstn(rstn), .romaddr(romaddr), .romreq(romreq), .romack(romack),
        .romdata(romdata), .memaddr(memaddr), .memdata(memdata), .memce_n(memce_n), .memoe_n(memoe_n)
    );

    rom_resp #(.WAIT(0)) dut_w0 (
        .clk(clk), .rstn(rstn), .romaddr(a0), .romreq(req0), .romack(ack0),
        .romdata(data0), .memaddr(maddr0), .memdata(mdata0), .memce_n(ce0), .memoe_n(oe0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full 4-phase transaction on the WAIT=3 instance.
    task automatic do_req(input string nm, input logic [21:0] a, input int lat_e, input logic [7:0] byte_e);
        int lat, low, bad;
        @(negedge clk);
        romaddr = a;
        romreq  = 1'b1;
        @(posedge clk); #1;
        lat = 0; low = 0; bad = 0;
        while (romack !== 1'b1 && lat < 40) begin
            if (memce_n === 1'b0) begin
                low++;
                if (memaddr !== a[21:1] || memoe_n !== 1'b0) bad++;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, lat_e);
        chk({nm, " romdata"}, romdata, byte_e);
        chk({nm, " sram cycles"}, low, (lat_e == 1) ? 0 : WAIT + 1);
        chk({nm, " memaddr/oe"}, bad, 0);
        romreq = 1'b0;
        @(posedge clk); #1;
        chk({nm, " romack fall"}, romack, 1'b0);
        chk({nm, " romdata hold"}, romdata, byte_e);
        mv = 1'b1;
        mt = a[21:1];
    endtask

    // One transaction on the WAIT=0 instance; returns right after romack falls.
    task automatic w0_req(input string nm, input logic [21:0] a, input logic [7:0] byte_e);
        int lat;
        @(negedge clk);
        a0   = a;
        req0 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (ack0 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, 2);
        chk({nm, " romdata"}, data0, byte_e);
        req0 = 1'b0;
        @(posedge clk); #1;
        chk({nm, " romack fall"}, ack0, 1'b0);
    endtask

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  byte_e;
        int          lat_nc;
        int          lat_c;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int hi;
        logic [21:0] a, last;

        tbl[0] = '{22'h000010, 8'hEF, 5, 5};
        tbl[1] = '{22'h000011, 8'hBE, 5, 1};
        tbl[2] = '{22'h000020, 8'hEF, 5, 5};
        tbl[3] = '{22'h000021, 8'hBE, 5, 1};
        tbl[4] = '{22'h00003F, 8'hBE, 5, 5};
        tbl[5] = '{22'h000000, 8'hEF, 5, 5};

        rstn = 1'b1; romreq = 1'b0; romaddr = '0; req0 = 1'b0; a0 = '0;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset romack", romack, 1'b0);
        chk("reset romdata", romdata, 8'h00);
        chk("reset memce_n", memce_n, 1'b1);
        chk("reset memoe_n", memoe_n, 1'b1);
        chk("reset memaddr", memaddr, 21'h0);
        @(negedge clk) rstn = 1'b1;

        for (int i = 0; i < 6; i++)
            do_req($sformatf("vec%0d", i), tbl[i].addr, CACHE ? tbl[i].lat_c : tbl[i].lat_nc, tbl[i].byte_e);

        last = 22'h0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = {last[21:1], ~last[0]};
                1:       a = 22'($urandom_range(0, 127));
                default: a = 22'($urandom);
            endcase
            do_req($sformatf("rnd%0d", i), a, exp_lat(a), exp_byte(a));
            last = a;
        end

        // romreq withdrawn during READ: read completes, one-cycle romack, back to IDLE.
        @(negedge clk);
        romaddr = 22'h000030;
        romreq  = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        hi = (romack === 1'b1) ? 1 : 0;
        romreq = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (romack === 1'b1) hi++;
        end
        chk("early drop pulse", hi, 1);
        mv = 1'b1;
        mt = 21'h000018;
        do_req("after drop", 22'h000031, exp_lat(22'h000031), exp_byte(22'h000031));

        // Reset during the second READ cycle discards the access.
        @(negedge clk);
        romaddr = 22'h000040;
        romreq  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("midread rst memce_n", memce_n, 1'b1);
        chk("midread rst memoe_n", memoe_n, 1'b1);
        chk("midread rst romack", romack, 1'b0);
        chk("midread rst memaddr", memaddr, 21'h0);
        chk("midread rst romdata", romdata, 8'h00);
        romreq = 1'b0;
        mv = 1'b0;
        @(negedge clk) rstn = 1'b1;
        hi = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (romack === 1'b1) hi++;
        end
        chk("post reset romack", hi, 0);
        do_req("post reset miss", 22'h000021, exp_lat(22'h000021), exp_byte(22'h000021));

        // WAIT=0 back-to-back: second request accepted on the edge after romack falls.
        w0_req("w0 first", 22'h000000, 8'hEF);
        w0_req("w0 second", 22'h000002, 8'hEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/rom_resp.md
ROM_RESP -- requirements
Module: rom_resp

Interface
REQ-001 SHALL have parameter: WAIT, default 3, number of extra SRAM access cycles beyond the first (legal 0..15).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rstn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: romaddr  input  22  byte address from requester, valid while romreq high.
REQ-005 SHALL have port: romreq  input  1  request, 4-phase handshake.
REQ-006 SHALL have port: romack  output  1  acknowledge, registered.
REQ-007 SHALL have port: romdata  output  8  read byte, registered, stable while romack high.
REQ-008 SHALL have port: memaddr  output  21  external SRAM word address.
REQ-009 SHALL have port: memdata  input  16  external SRAM read data.
REQ-010 SHALL have port: memce_n  output  1  SRAM chip enable, active-low, registered.
REQ-011 SHALL have port: memoe_n  output  1  SRAM output enable, active-low, registered.

Function
REQ-012 SHALL implement FSM states IDLE, READ, ACK; the cache feature adds no state.
REQ-013 IDLE: on edge sampling romreq=1, SHALL latch romaddr and go to READ; memaddr = latched romaddr[21:1].
REQ-014 READ: memce_n=memoe_n=0; SHALL stay WAIT+1 cycles (counter from WAIT down to 0), then sample memdata and go to ACK.
REQ-015 Byte select SHALL be little-endian: latched romaddr[0]=0 -> memdata[7:0], 1 -> memdata[15:8].
REQ-016 ACK: romack=1, memce_n=memoe_n=1; on edge sampling romreq=0 SHALL clear romack and go to IDLE.
REQ-017 Latency: romack SHALL rise WAIT+2 edges after the edge sampling romreq high (WAIT=3 -> 5 edges).
REQ-018 romdata SHALL update only on entry to ACK and hold its value in IDLE.
REQ-019 romreq falling during READ SHALL not abort the read; ACK is entered, romack high one cycle, then IDLE.
REQ-020 romreq high in IDLE on the cycle after romack falls SHALL be accepted as a new request (back-to-back).
REQ-021 WAIT=0 SHALL give a single READ cycle; counter width = max(1, clog2(WAIT+1)).

Reset
REQ-022 rstn low SHALL immediately force IDLE, romack=0, romdata=0, memce_n=1, memoe_n=1, memaddr=0, counter=0.
REQ-023 Reset mid-READ or mid-ACK SHALL discard the access; no romack pulse after release without a new romreq.

Configuration
REQ-024 Macro ROM_RESP_CACHE_EN SHALL enable a one-word line buffer (tag = romaddr[21:1], 16-bit data, valid bit).
REQ-025 With ROM_RESP_CACHE_EN: IDLE request whose tag matches a valid line SHALL go straight to ACK, romack rising 1 edge after sampling, no SRAM cycle.
REQ-026 With ROM_RESP_CACHE_EN: every completed READ SHALL fill the line; reset clears valid.
REQ-027 Without ROM_RESP_CACHE_EN: every request SHALL perform a READ; no buffer registers exist.

Structure
REQ-028 Shared package rom_pkg SHALL hold the FSM state type, ROM_AW=22, MEM_DW=16 constants.
REQ-029 Line buffer SHALL be sub-module rom_resp_cache, instantiated only under ROM_RESP_CACHE_EN.

Verification
REQ-030 WAIT=3, romaddr=0x000010, memdata=0xBEEF -> romack rises 5 edges after sampling, romdata=0xEF; drop romreq -> romack low next edge.
REQ-031 romaddr=0x000011, memdata=0xBEEF -> romdata=0xBE; memaddr=0x000008 throughout READ.
REQ-032 Cache on: read 0x000020 then 0x000021 -> second romack after 1 edge, memce_n stays 1; cache off -> second takes 5 edges.
REQ-033 rstn low during READ cycle 2 -> memce_n=1, romack=0 immediately; release with romreq low -> romack stays 0.
REQ-034 WAIT=0, back-to-back requests 0x000000/0x000002 -> each romack 2 edges after acceptance, second accepted edge after romack falls.
REQ-035 romreq dropped in READ -> romack high exactly one cycle, FSM back in IDLE.
